// File: rtl/kbd_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// shifts out one byte with odd parity and stop bit, then checks the device ack.
module kbd_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       kbdclk_in,
  input  logic       kbddat_in,
  output logic       kbdclk_oe,
  output logic       kbddat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE} state_e;

  state_e        state_q;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [9:0]    frame_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic [TW-1:0] tout_q;
  logic          busy_q, done_q, err_q, clk_oe_q, dat_oe_q;

  logic clk_s, dat_s, clk_fall;
  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_s;

  // Synchronizers reset to the idle-high line state so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], kbdclk_in};
      dat_sync_q <= {dat_sync_q[0], kbddat_in};
      clk_prev_q <= clk_s;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            frame_q   <= {1'b1, ~^tx_data, tx_data};
            inh_cnt_q <= '0;
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            dat_oe_q  <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            dat_oe_q <= 1'b1;
            state_q  <= RTS;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        RTS: begin
          clk_oe_q  <= 1'b0;
          tout_q    <= '0;
          bit_cnt_q <= '0;
          state_q   <= BITS;
        end
        BITS, ACK, WAIT_IDLE: begin
          if (tout_q == TO_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= IDLE;
          end else begin
            tout_q <= tout_q + 1'b1;
            case (state_q)
              BITS: begin
                if (clk_fall) begin
                  // Frame shifts out LSB first; the stop bit (1) releases the line.
                  dat_oe_q  <= ~frame_q[0];
                  frame_q   <= {1'b0, frame_q[9:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 4'd9) state_q <= ACK;
                end
              end
              ACK: begin
                if (clk_fall) begin
                  if (!dat_s) begin
                    state_q <= WAIT_IDLE;
                  end else begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                  end
                end
              end
              WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign kbdclk_oe = clk_oe_q;
  assign kbddat_oe = dat_oe_q;

endmodule

// File: tb/tb_kbd_tx.sv
// Testbench for kbd_tx: a PS/2 device model clocks frames out of the host,
// table-driven transfers plus hand-written timeout, reset and back-to-back cases.
module tb_kbd_tx;

  localparam int INH  = 40;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, err;
  logic       kbdclk_in, kbddat_in, kbdclk_oe, kbddat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // Open-drain lines with pull-ups: either side may pull low.
  assign kbdclk_in = ~(kbdclk_oe | dev_clk_low);
  assign kbddat_in = ~(kbddat_oe | dev_dat_low);

  kbd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .err(err),
    .kbdclk_in(kbdclk_in), .kbddat_in(kbddat_in),
    .kbdclk_oe(kbdclk_oe), .kbddat_oe(kbddat_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, rts_cnt = 0, viol = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (kbdclk_oe && !kbddat_oe) inh_cnt++;
    if (kbdclk_oe && kbddat_oe) rts_cnt++;
    if ((done && err) || ((done || err) && busy)) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Returns on the first negedge of the bit phase: clock released, start bit driven.
  task automatic wait_bits(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH * 4; i++) begin
      @(negedge clk);
      if (!kbdclk_oe && kbddat_oe && busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One device clock period: sample data late in the high phase, then pulse low.
  task automatic dev_clock(input bit drive_ack, output logic s);
    repeat (HALF) @(negedge clk);
    s = kbddat_in;
    if (drive_ack) dev_dat_low = 1'b1;
    repeat (2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
  endtask

  task automatic run_frame(input bit ack, input bit poke, output logic [10:0] seen);
    logic s;
    for (int k = 0; k < 11; k++) begin
      if (poke && k == 3) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      dev_clock(ack && k == 10, s);
      seen[k] = s;
    end
    dev_dat_low = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          poke;
    logic [10:0] frame;
    int          n_done;
    int          n_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, i0, r0, n;
    bit ok;
    logic [10:0] seen;

    // Frame vectors are {stop, parity, d7..d0, start}; index k = k-th sampled bit.
    vecs[0] = '{8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 0, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1, 0};

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_clk_oe", kbdclk_oe, 0);
    check("reset_dat_oe", kbddat_oe, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt;
      send(vecs[v].data);
      check($sformatf("v%0d_busy_after_start", v), busy, 1);
      wait_bits(ok);
      check($sformatf("v%0d_bits_entry", v), ok, 1);
      run_frame(vecs[v].ack, vecs[v].poke, seen);
      check($sformatf("v%0d_frame", v), seen, vecs[v].frame);
      check($sformatf("v%0d_inhibit_cycles", v), inh_cnt - i0, INH);
      check($sformatf("v%0d_rts_cycles", v), rts_cnt - r0, 1);
      check($sformatf("v%0d_done_pulses", v), done_cnt - d0, vecs[v].n_done);
      check($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].n_err);
      check($sformatf("v%0d_busy_after", v), busy, 0);
      check($sformatf("v%0d_oe_released", v), {kbdclk_oe, kbddat_oe}, 0);
    end

    // A start in the done cycle is accepted on the next edge.
    send(8'hA5);
    wait_bits(ok);
    run_frame(1'b1, 1'b0, seen);
    ok = 1'b0;
    send(8'h96);
    wait_bits(ok);
    for (int k = 0; k < 11; k++) dev_clock(k == 10, seen[k]);
    dev_dat_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", ok, 1);
    check("b2b_busy_in_done_cycle", busy, 0);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_accepted", busy, 1);
    d0 = done_cnt;
    wait_bits(ok);
    run_frame(1'b1, 1'b0, seen);
    check("b2b_frame", seen, {1'b1, 1'b1, 8'h3C, 1'b0});
    check("b2b_done", done_cnt - d0, 1);

    // Device never clocks: err exactly TO cycles after bit-phase entry.
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    wait_bits(ok);
    check("to_bits_entry", ok, 1);
    n = 0;
    for (int i = 0; i < TO + 50; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    check("to_cycles", n, TO);
    check("to_err", err, 1);
    check("to_oe_released", {kbdclk_oe, kbddat_oe}, 0);
    check("to_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("to_done_none", done_cnt - d0, 0);
    check("to_err_once", err_cnt - e0, 1);

    // Reset during bit 4 releases everything on that edge, no pulses.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    wait_bits(ok);
    for (int k = 0; k < 4; k++) dev_clock(1'b0, seen[k]);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, err, kbdclk_oe, kbddat_oe}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_err", err_cnt - e0, 0);
    send(8'hED);
    wait_bits(ok);
    check("rst_after_bits_entry", ok, 1);
    run_frame(1'b1, 1'b0, seen);
    check("rst_after_frame", seen, {1'b1, 1'b1, 8'hED, 1'b0});
    check("rst_after_done", done_cnt - d0, 1);

    check("done_err_busy_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
